// File: rtl/hex_pkg.sv
// Shared types and constants for the binary-to-seven-segment feed.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package hex_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_DASH  = 7'h40;

  localparam int unsigned BCD_MAX = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

endpackage

// File: rtl/bin_to_seg_encoder_seg7_decode.sv
// One BCD digit to its seven-segment pattern; non-decimal codes go blank.
module seg7_decode
  import hex_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_seg_encoder.sv
// Binary to four-digit seven-segment patterns via sequential double-dabble.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the leading nonzero digit.
module bin_to_seg_encoder
  import hex_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output seg_t            seg0,
  output seg_t            seg1,
  output seg_t            seg2,
  output seg_t            seg3,
  output logic            seg_valid
);

  localparam int CNT_W = $clog2(IN_W);

  state_t            state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  seg_t              seg0_q, seg1_q, seg2_q, seg3_q;
  seg_t              seg0_d, seg1_d, seg2_d, seg3_d;
  logic              seg_valid_q, seg_valid_d;
  logic [16+IN_W-1:0] shifted;
  seg_t              dec0, dec1, dec2, dec3;
  seg_t              disp0, disp1, disp2, disp3;

  seg7_decode u_dec0 (.digit(bcd_q[3:0]),   .seg(dec0));
  seg7_decode u_dec1 (.digit(bcd_q[7:4]),   .seg(dec1));
  seg7_decode u_dec2 (.digit(bcd_q[11:8]),  .seg(dec2));
  seg7_decode u_dec3 (.digit(bcd_q[15:12]), .seg(dec3));

  always_comb begin
    disp0 = dec0;
    disp1 = dec1;
    disp2 = dec2;
    disp3 = dec3;
`ifdef LEADING_ZERO_BLANK_EN
    // seg0 is never blanked so zero still shows a single "0"
    if (bcd_q[15:12] == 4'd0) disp3 = SEG_BLANK;
    if (bcd_q[15:8] == 8'd0)  disp2 = SEG_BLANK;
    if (bcd_q[15:4] == 12'd0) disp1 = SEG_BLANK;
`else
    disp0 = dec0;
`endif
    if (ovf_q) begin
      disp0 = SEG_DASH;
      disp1 = SEG_DASH;
      disp2 = SEG_DASH;
      disp3 = SEG_DASH;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    seg0_d      = seg0_q;
    seg1_d      = seg1_q;
    seg2_d      = seg2_q;
    seg3_d      = seg3_q;
    seg_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 32'(in_data) > BCD_MAX;
        end
      end
      SHIFT: begin
        bcd_d = shifted[16+IN_W-1:IN_W];
        bin_d = shifted[IN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W - 1)) state_d = ENCODE;
      end
      ENCODE: begin
        seg0_d      = disp0;
        seg1_d      = disp1;
        seg2_d      = disp2;
        seg3_d      = disp3;
        seg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      seg0_q      <= SEG_BLANK;
      seg1_q      <= SEG_BLANK;
      seg2_q      <= SEG_BLANK;
      seg3_q      <= SEG_BLANK;
      seg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      seg0_q      <= seg0_d;
      seg1_q      <= seg1_d;
      seg2_q      <= seg2_d;
      seg3_q      <= seg3_d;
      seg_valid_q <= seg_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign seg0      = seg0_q;
  assign seg1      = seg1_q;
  assign seg2      = seg2_q;
  assign seg3      = seg3_q;
  assign seg_valid = seg_valid_q;

endmodule

// File: tb/tb_bin_to_seg_encoder.sv
// Randomized, self-checking bench for bin_to_seg_encoder against a decimal reference model.
module tb_bin_to_seg_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        seg_valid;

  int errors = 0;
  int checks = 0;

  bin_to_seg_encoder #(.IN_W(14)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg_valid(seg_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Expected display {seg3,seg2,seg1,seg0} from the decimal value itself.
  function automatic logic [27:0] model(input int v);
    logic [6:0] s3, s2, s1, s0;
    if (v > 9999) return {4{7'h40}};
    s0 = digit_pattern(v % 10);
    s1 = digit_pattern((v / 10) % 10);
    s2 = digit_pattern((v / 100) % 10);
    s3 = digit_pattern(v / 1000);
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 1000) s3 = 7'h00;
    if (v < 100)  s2 = 7'h00;
    if (v < 10)   s1 = 7'h00;
`endif
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accept and observes 18 cycles; returns what was seen.
  task automatic do_convert(input int value, input bit hold, input int hold_data,
                            output int lat, output int pulses, output int ready_errs,
                            output logic [27:0] segs);
    int w;
    lat = 0; pulses = 0; ready_errs = 0; segs = '0;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    in_data  = 14'(value);
    in_valid = 1'b1;
    tick();
    if (hold) in_data = 14'(hold_data);
    else in_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 15) in_valid = 1'b0;
      if (seg_valid) begin
        pulses++;
        if (lat == 0) begin
          lat  = k;
          segs = {seg3, seg2, seg1, seg0};
        end
      end
      if (k < 15 && in_ready) ready_errs++;
      if (k >= 15 && !in_ready) ready_errs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if ({seg3, seg2, seg1, seg0, seg_valid} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%b want 0/0", {seg3, seg2, seg1, seg0}, seg_valid);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || seg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b want 1/0", in_ready, seg_valid);
    end
  endtask

  task automatic test_value(input string name, input int value, input bit hold, input int hold_data);
    int lat, pulses, ready_errs;
    logic [27:0] segs, exp;
    exp = model(value);
    do_convert(value, hold, hold_data, lat, pulses, ready_errs, segs);
    checks++;
    if (lat !== 15) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 15", name, lat); end
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL %s_pulses: got %0d want 1", name, pulses); end
    checks++;
    if (ready_errs !== 0) begin errors++; $display("[TB] FAIL %s_ready: got %0d bad cycles want 0", name, ready_errs); end
    checks++;
    if (segs !== exp) begin errors++; $display("[TB] FAIL %s_segs: got %h want %h", name, segs, exp); end
    checks++;
    if ({seg3, seg2, seg1, seg0} !== exp) begin
      errors++;
      $display("[TB] FAIL %s_hold: got %h want %h", name, {seg3, seg2, seg1, seg0}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp1, exp2;
    exp1 = model(9999);
    exp2 = model(10000);
    in_data  = 14'd9999;
    in_valid = 1'b1;
    tick();
    in_data = 14'd10000;
    for (int k = 1; k <= 15; k++) tick();
    checks++;
    if (seg_valid !== 1'b1 || in_ready !== 1'b1 || {seg3, seg2, seg1, seg0} !== exp1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got v=%b r=%b %h want 1/1 %h", seg_valid, in_ready, {seg3, seg2, seg1, seg0}, exp1);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || seg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept_e16: got r=%b v=%b want 0/0", in_ready, seg_valid);
    end
    for (int k = 1; k <= 14; k++) tick();
    checks++;
    if (seg_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early: got %b want 0", seg_valid); end
    tick();
    checks++;
    if (seg_valid !== 1'b1 || {seg3, seg2, seg1, seg0} !== exp2) begin
      errors++;
      $display("[TB] FAIL b2b_second: got v=%b %h want 1 %h", seg_valid, {seg3, seg2, seg1, seg0}, exp2);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int stray, bad_ready;
    in_data  = 14'd5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({seg3, seg2, seg1, seg0} !== 28'd0 || seg_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_reset: got %h v=%b r=%b want 0 0 1", {seg3, seg2, seg1, seg0}, seg_valid, in_ready);
    end
    tick(); tick();
    rst = 1'b0;
    stray = 0; bad_ready = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (seg_valid) stray++;
      if (!in_ready) bad_ready++;
    end
    checks++;
    if (stray !== 0 || bad_ready !== 0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got pulses=%0d busy=%0d want 0/0", stray, bad_ready);
    end
    test_value("after_abort", 5, 1'b0, 0);
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 3) v = int'($urandom_range(10000, 16383));
      else v = int'($urandom_range(0, 9999));
      test_value("random", v, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_value("v1234", 1234, 1'b0, 0);
    test_value("v0", 0, 1'b0, 0);
    test_back_to_back();
    test_value("busy_ignore", 42, 1'b1, 7);
    test_reset_abort();
    test_value("max", 16383, 1'b0, 0);
    test_value("v9", 9, 1'b0, 0);
    test_value("v10", 10, 1'b0, 0);
    test_value("v1000", 1000, 1'b0, 0);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
